avg_lanes_beats: RTL and testbench

Streaming multi-beat averager, the next generation of the single-beat N-input averager. Each accepted beat carries LANES samples; the block accumulates BEATS consecutive beats and emits one average of LANES*BEATS samples, with selectable rounding. It sits between a multi-lane sample source and any downstream consumer that may stall, using valid/ready flow control on both sides.

---
 rtl/avg_lanes_beats.sv | 101 ++++++++++
 tb/tb_avg_lanes_beats.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_lanes_beats.sv
// Streaming multi-beat averager: sums BEATS beats of LANES unsigned samples and
// emits their mean through a valid/ready output register with optional rounding.
module avg_lanes_beats #(
    parameter int LANES  = 4,
    parameter int BEATS  = 4,
    parameter int DWIDTH = 8,
    parameter int ROUND  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DWIDTH-1:0] i_dat_vector,
    input  logic                    i_dat_valid,
    output logic                    o_dat_ready,
    input  logic                    i_restart,
    output logic [DWIDTH-1:0]       o_avg,
    output logic                    o_avg_valid,
    input  logic                    i_avg_ready
);

    localparam int N     = LANES * BEATS;
    localparam int SHIFT = $clog2(N);
    localparam int SUMW  = DWIDTH + SHIFT;
    localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [SUMW-1:0] RND_ADD   = (ROUND != 0) ? SUMW'(N / 2) : '0;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

    logic [SUMW-1:0]   acc_q, acc_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [DWIDTH-1:0] avg_q, avg_d;
    logic              avg_valid_q, avg_valid_d;

    logic [SUMW-1:0]   lane_sum;
    logic [SUMW-1:0]   base_acc;
    logic [CNTW-1:0]   base_cnt;
    logic [SUMW-1:0]   final_sum;
    logic              accept;
    logic              final_beat;

    // Input stalls whenever a held result cannot drain this cycle.
    assign o_dat_ready = !avg_valid_q || i_avg_ready;
    assign accept      = i_dat_valid && o_dat_ready;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + SUMW'(i_dat_vector[k*DWIDTH +: DWIDTH]);
        end
    end

    // A restart with a simultaneous beat makes that beat beat 0 of the new group.
    always_comb begin
        base_acc   = i_restart ? '0 : acc_q;
        base_cnt   = i_restart ? '0 : cnt_q;
        final_beat = accept && (base_cnt == LAST_BEAT);
        final_sum  = base_acc + lane_sum + RND_ADD;

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_d       = avg_q;
        avg_valid_d = avg_valid_q;

        if (final_beat) begin
            acc_d       = '0;
            cnt_d       = '0;
            avg_d       = DWIDTH'(final_sum >> SHIFT);
            avg_valid_d = 1'b1;
        end else begin
            if (accept) begin
                acc_d = base_acc + lane_sum;
                cnt_d = base_cnt + CNTW'(1);
            end else if (i_restart) begin
                acc_d = '0;
                cnt_d = '0;
            end
            if (avg_valid_q && i_avg_ready) begin
                avg_valid_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign o_avg       = avg_q;
    assign o_avg_valid = avg_valid_q;

endmodule

// File: tb/tb_avg_lanes_beats.sv
// Bench for avg_lanes_beats: truncating and rounding instances share one stimulus
// stream; expected averages are queued per instance and checked on each handshake.
module tb_avg_lanes_beats;

    localparam int LANES  = 4;
    localparam int BEATS  = 4;
    localparam int DWIDTH = 8;
    localparam int BUDGET = 50;

    logic                    clk;
    logic                    rst;
    logic [LANES*DWIDTH-1:0] dat_vec;
    logic                    dat_valid;
    logic                    restart;
    logic                    avg_ready;
    logic                    dat_ready0, dat_ready1;
    logic [DWIDTH-1:0]       avg0, avg1;
    logic                    avg_valid0, avg_valid1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DWIDTH-1:0] q0[$];
    logic [DWIDTH-1:0] q1[$];

    typedef struct {
        string           name;
        logic [3:0][31:0] beat;
        logic [7:0]      exp_r0;
        logic [7:0]      exp_r1;
    } vec_t;

    vec_t tbl[8];

    avg_lanes_beats #(.LANES(LANES), .BEATS(BEATS), .DWIDTH(DWIDTH), .ROUND(0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .i_dat_vector (dat_vec),
        .i_dat_valid  (dat_valid),
        .o_dat_ready  (dat_ready0),
        .i_restart    (restart),
        .o_avg        (avg0),
        .o_avg_valid  (avg_valid0),
        .i_avg_ready  (avg_ready)
    );

    avg_lanes_beats #(.LANES(LANES), .BEATS(BEATS), .DWIDTH(DWIDTH), .ROUND(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .i_dat_vector (dat_vec),
        .i_dat_valid  (dat_valid),
        .o_dat_ready  (dat_ready1),
        .i_restart    (restart),
        .o_avg        (avg1),
        .o_avg_valid  (avg_valid1),
        .i_avg_ready  (avg_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] b3,
                                input logic [7:0] e0, input logic [7:0] e1);
        vec_t v;
        v.name    = n;
        v.beat[0] = b0;
        v.beat[1] = b1;
        v.beat[2] = b2;
        v.beat[3] = b3;
        v.exp_r0  = e0;
        v.exp_r1  = e1;
        return v;
    endfunction

    // Present one beat (caller sits just after a rising edge), wait for acceptance.
    task automatic beat(input logic [31:0] v, input logic rs, input logic last,
                        input logic [7:0] e0, input logic [7:0] e1);
        int waited;
        dat_vec   = v;
        dat_valid = 1'b1;
        restart   = rs;
        waited    = 0;
        @(negedge clk);
        while (!dat_ready0 && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        check("dat_ready_wait", 32'(dat_ready0), 1);
        if (last) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        @(posedge clk);
        #1;
        dat_valid = 1'b0;
        restart   = 1'b0;
    endtask

    task automatic group4(input logic [31:0] v, input logic [7:0] e0, input logic [7:0] e1);
        for (int b = 0; b < BEATS; b++) begin
            beat(v, 1'b0, (b == BEATS - 1), e0, e1);
        end
    endtask

    // Scoreboard: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid_agree", 32'(avg_valid1), 32'(avg_valid0));
            if (avg_valid0 && avg_ready) begin
                if (q0.size() == 0) begin
                    check("result0_expected", q0.size(), 1);
                end else begin
                    check("avg_round0", 32'(avg0), 32'(q0.pop_front()));
                end
            end
            if (avg_valid1 && avg_ready) begin
                if (q1.size() == 0) begin
                    check("result1_expected", q1.size(), 1);
                end else begin
                    check("avg_round1", 32'(avg1), 32'(q1.pop_front()));
                end
            end
        end
    end

    initial begin
        tbl[0] = mk("all10",    32'h0A0A0A0A, 32'h0A0A0A0A, 32'h0A0A0A0A, 32'h0A0A0A0A, 8'd10,  8'd10);
        tbl[1] = mk("all255",   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd255, 8'd255);
        tbl[2] = mk("all0",     32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 8'd0,   8'd0);
        tbl[3] = mk("half24",   32'h00080808, 32'h00000000, 32'h00000000, 32'h00000000, 8'd1,   8'd2);
        tbl[4] = mk("sum23",    32'h00070808, 32'h00000000, 32'h00000000, 32'h00000000, 8'd1,   8'd1);
        tbl[5] = mk("ramp",     32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201, 8'd2,   8'd3);
        tbl[6] = mk("near_max", 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd254, 8'd255);
        tbl[7] = mk("lane_sep", 32'h000000FF, 32'h0000FF00, 32'h00FF0000, 32'hFF000000, 8'd63,  8'd64);

        rst       = 1'b1;
        dat_vec   = '0;
        dat_valid = 1'b0;
        restart   = 1'b0;
        avg_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_avg",   32'(avg0), 0);
        check("reset_valid", 32'(avg_valid0), 0);
        check("reset_ready", 32'(dat_ready0), 1);
        @(posedge clk);
        #1;

        // Latency: valid rises on the final-beat edge, drops a cycle later.
        for (int b = 0; b < BEATS - 1; b++) beat(32'h0A0A0A0A, 1'b0, 1'b0, 8'd0, 8'd0);
        check("lat_not_early", 32'(avg_valid0), 0);
        beat(32'h0A0A0A0A, 1'b0, 1'b1, 8'd10, 8'd10);
        @(negedge clk);
        check("lat_valid_high", 32'(avg_valid0), 1);
        check("lat_avg", 32'(avg0), 10);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_valid_low", 32'(avg_valid0), 0);
        @(posedge clk);
        #1;

        // Table-driven groups at full throughput.
        for (int t = 0; t < 8; t++) begin
            for (int b = 0; b < BEATS; b++) begin
                beat(tbl[t].beat[b], 1'b0, (b == BEATS - 1), tbl[t].exp_r0, tbl[t].exp_r1);
            end
        end
        @(negedge clk);
        @(posedge clk);
        #1;

        // Backpressure: a result of 50 held while 70-beats are offered.
        avg_ready = 1'b0;
        group4(32'h32323232, 8'd50, 8'd50);
        dat_vec   = 32'h46464646;
        dat_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_avg_stable", 32'(avg0), 50);
            check("bp_valid_held", 32'(avg_valid0), 1);
            check("bp_ready_low",  32'(dat_ready0), 0);
        end
        @(posedge clk);
        #1;
        avg_ready = 1'b1;
        group4(32'h46464646, 8'd70, 8'd70);
        @(negedge clk);
        check("bp_second_valid", 32'(avg_valid0), 1);
        check("bp_second_avg",   32'(avg0), 70);
        @(posedge clk);
        #1;

        // Restart discards two beats of 100; restart alone keeps a held result.
        beat(32'h64646464, 1'b0, 1'b0, 8'd0, 8'd0);
        beat(32'h64646464, 1'b0, 1'b0, 8'd0, 8'd0);
        beat(32'h14141414, 1'b1, 1'b0, 8'd0, 8'd0);
        beat(32'h14141414, 1'b0, 1'b0, 8'd0, 8'd0);
        beat(32'h14141414, 1'b0, 1'b0, 8'd0, 8'd0);
        avg_ready = 1'b0;
        beat(32'h14141414, 1'b0, 1'b1, 8'd20, 8'd20);
        restart = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rs_hold_valid", 32'(avg_valid0), 1);
            check("rs_hold_avg",   32'(avg0), 20);
        end
        @(posedge clk);
        #1;
        restart   = 1'b0;
        avg_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;

        // Reset mid-group discards the partial sum.
        for (int b = 0; b < BEATS - 1; b++) beat(32'hC8C8C8C8, 1'b0, 1'b0, 8'd0, 8'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_avg",   32'(avg0), 0);
        check("mid_rst_valid", 32'(avg_valid0), 0);
        check("mid_rst_ready", 32'(dat_ready0), 1);
        @(posedge clk);
        #1;
        group4(32'h28282828, 8'd40, 8'd40);

        repeat (4) @(posedge clk);
        #1;
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("final_idle", 32'(avg_valid0), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
